// File: rtl/mux_scan_collector_pkg.sv
// Shared types and constants for the mux scan collector.
// Holds the FSM encoding, channel/select widths and the output word type.
package mux_scan_collector_pkg;

  localparam int SCAN_NUM_CH = 8;
  localparam int SCAN_SEL_W  = 3;
  localparam int SCAN_CNT_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  typedef logic [SCAN_NUM_CH-1:0] word_t;

endpackage

// File: rtl/mux_scan_outreg.sv
// Single-entry valid/ready output register with completed-word counter.
// Ports: clock, reset, load/word in, ready in; free, valid, bits, count out.
module mux_scan_outreg
  import mux_scan_collector_pkg::*;
#(
  parameter int NUM_CH = SCAN_NUM_CH,
  parameter int CNT_W  = SCAN_CNT_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic [NUM_CH-1:0] word,
  input  logic              ready,
  output logic              free,
  output logic              valid,
  output logic [NUM_CH-1:0] bits,
  output logic [CNT_W-1:0]  count
);

  // Free when empty, or when the held word leaves on this edge.
  assign free = ~valid | ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      valid <= 1'b0;
      bits  <= '0;
      count <= '0;
    end else if (load) begin
      valid <= 1'b1;
      bits  <= word;
      count <= count + 1'b1;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/mux_scan_collector.sv
// Steps an 8:1 mux select, packs the sampled bits into a word (bit k =
// channel k) and hands it downstream. Ports: clock, reset, io_start,
// io_continuous, io_sel, io_mux_out, io_busy, io_out_valid/ready/bits,
// io_word_count.
module mux_scan_collector
  import mux_scan_collector_pkg::*;
#(
  parameter int NUM_CH = SCAN_NUM_CH,
  parameter int SEL_W  = SCAN_SEL_W,
  parameter int CNT_W  = SCAN_CNT_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              io_start,
  input  logic              io_continuous,
  output logic [SEL_W-1:0]  io_sel,
  input  logic              io_mux_out,
  output logic              io_busy,
  output logic              io_out_valid,
  input  logic              io_out_ready,
  output logic [NUM_CH-1:0] io_out_bits,
  output logic [CNT_W-1:0]  io_word_count
);

  state_t            state;
  state_t            state_n;
  logic [SEL_W-1:0]  idx;
  logic [NUM_CH-1:0] collect;
  logic [NUM_CH-1:0] word;
  logic              last;
  logic              free;
  logic              load;

  assign last   = (idx == SEL_W'(NUM_CH - 1));
  assign io_sel = idx;

  // Collect register with the current sample merged in, so the
  // final bit is part of the word loaded on the completing edge.
  always_comb begin
    word = collect;
    if (state == ST_SCAN) word[idx] = io_mux_out;
  end

  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      ST_IDLE: begin
        if (io_start) state_n = ST_SCAN;
      end
      ST_SCAN: begin
        if (last) begin
          if (!free)              state_n = ST_HOLD;
          else if (io_continuous) state_n = ST_SCAN;
          else                    state_n = ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (free) begin
          if (io_continuous) state_n = ST_SCAN;
          else               state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_comb begin
    load    = free &&
              ((state == ST_SCAN && last) ||
               (state == ST_HOLD));
    io_busy = (state != ST_IDLE);
  end

  // Index steps during a scan; it stays at the last
  // channel while a completed word waits in HOLD.
  always_ff @(posedge clock) begin
    if (reset) begin
      idx <= '0;
    end else if (state == ST_SCAN && !last) begin
      idx <= idx + 1'b1;
    end else if (state_n != ST_HOLD) begin
      idx <= '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset)                 collect <= '0;
    else if (state == ST_SCAN) collect <= word;
  end

  mux_scan_outreg #(
    .NUM_CH (NUM_CH),
    .CNT_W  (CNT_W)
  ) u_outreg (
    .clock (clock),
    .reset (reset),
    .load  (load),
    .word  (word),
    .ready (io_out_ready),
    .free  (free),
    .valid (io_out_valid),
    .bits  (io_out_bits),
    .count (io_word_count)
  );

endmodule

// File: tb/tb_mux_scan_collector.sv
// Directed bench for mux_scan_collector.
// The mux is modelled as pat[io_sel]; expected values are hand-computed.
module tb_mux_scan_collector;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic       cont;
  logic [2:0] sel;
  logic       mux_out;
  logic       busy;
  logic       valid;
  logic       ready;
  logic [7:0] bits;
  logic [7:0] count;
  logic [7:0] pat;
  logic [7:0] exp_count;
  int         checks;
  int         errors;

  always #5 clock = ~clock;

  assign mux_out = pat[sel];

  mux_scan_collector dut (
    .clock         (clock),
    .reset         (reset),
    .io_start      (start),
    .io_continuous (cont),
    .io_sel        (sel),
    .io_mux_out    (mux_out),
    .io_busy       (busy),
    .io_out_valid  (valid),
    .io_out_ready  (ready),
    .io_out_bits   (bits),
    .io_word_count (count)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic launch(input logic [7:0] p);
    pat   = p;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    cont  = 1'b0;
    ready = 1'b1;
    pat   = 8'h00;
    tick();
    tick();
    reset = 1'b0;
    checks++;
    if ({sel, busy, valid, bits, count} !== 21'd0) begin
      errors++;
      $display("FAIL reset_state got sel=%0d busy=%b valid=%b bits=%h cnt=%0d exp all zero",
               sel, busy, valid, bits, count);
    end
    exp_count = 8'd0;
  endtask

  task automatic test_single();
    cont  = 1'b0;
    ready = 1'b1;
    launch(8'hA5);
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (sel !== 3'(k) || busy !== 1'b1 || valid !== 1'b0) begin
        errors++;
        $display("FAIL single_sel got sel=%0d busy=%b valid=%b exp sel=%0d busy=1 valid=0",
                 sel, busy, valid, k);
      end
      tick();
    end
    exp_count++;
    checks++;
    if (valid !== 1'b1 || bits !== 8'hA5 || count !== exp_count || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_word got v=%b bits=%h cnt=%0d busy=%b exp v=1 bits=a5 cnt=%0d busy=0",
               valid, bits, count, busy, exp_count);
    end
    tick();
    checks++;
    if (valid !== 1'b0 || sel !== 3'd0) begin
      errors++;
      $display("FAIL single_drain got v=%b sel=%0d exp v=0 sel=0", valid, sel);
    end
  endtask

  task automatic test_continuous();
    cont  = 1'b1;
    ready = 1'b1;
    launch(8'h3C);
    repeat (8) tick();
    exp_count++;
    checks++;
    if (valid !== 1'b1 || bits !== 8'h3C || sel !== 3'd0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL cont_word1 got v=%b bits=%h sel=%0d busy=%b exp v=1 bits=3c sel=0 busy=1",
               valid, bits, sel, busy);
    end
    pat = 8'hF0;
    tick();
    checks++;
    if (valid !== 1'b0 || sel !== 3'd1) begin
      errors++;
      $display("FAIL cont_gap got v=%b sel=%0d exp v=0 sel=1", valid, sel);
    end
    repeat (7) tick();
    exp_count++;
    checks++;
    if (valid !== 1'b1 || bits !== 8'hF0 || sel !== 3'd0 || count !== exp_count) begin
      errors++;
      $display("FAIL cont_word2 got v=%b bits=%h sel=%0d cnt=%0d exp v=1 bits=f0 sel=0 cnt=%0d",
               valid, bits, sel, count, exp_count);
    end
    cont = 1'b0;
    repeat (8) tick();
    exp_count++;
    checks++;
    if (valid !== 1'b1 || bits !== 8'hF0 || busy !== 1'b0 || count !== exp_count) begin
      errors++;
      $display("FAIL cont_stop got v=%b bits=%h busy=%b cnt=%0d exp v=1 bits=f0 busy=0 cnt=%0d",
               valid, bits, busy, count, exp_count);
    end
    tick();
  endtask

  task automatic test_hold();
    cont  = 1'b1;
    ready = 1'b0;
    launch(8'h5A);
    repeat (8) tick();
    exp_count++;
    checks++;
    if (valid !== 1'b1 || bits !== 8'h5A || sel !== 3'd0 || count !== exp_count) begin
      errors++;
      $display("FAIL hold_word1 got v=%b bits=%h sel=%0d cnt=%0d exp v=1 bits=5a sel=0 cnt=%0d",
               valid, bits, sel, count, exp_count);
    end
    pat = 8'hC3;
    repeat (12) tick();
    checks++;
    if (valid !== 1'b1 || bits !== 8'h5A || sel !== 3'd7 || busy !== 1'b1 ||
        count !== exp_count) begin
      errors++;
      $display("FAIL hold_wait got v=%b bits=%h sel=%0d busy=%b cnt=%0d exp v=1 bits=5a sel=7 busy=1 cnt=%0d",
               valid, bits, sel, busy, count, exp_count);
    end
    ready = 1'b1;
    tick();
    exp_count++;
    checks++;
    if (valid !== 1'b1 || bits !== 8'hC3 || sel !== 3'd0 || busy !== 1'b1 ||
        count !== exp_count) begin
      errors++;
      $display("FAIL hold_release got v=%b bits=%h sel=%0d busy=%b cnt=%0d exp v=1 bits=c3 sel=0 busy=1 cnt=%0d",
               valid, bits, sel, busy, count, exp_count);
    end
    cont = 1'b0;
    repeat (8) tick();
    exp_count++;
    checks++;
    if (valid !== 1'b1 || bits !== 8'hC3 || busy !== 1'b0 || count !== exp_count) begin
      errors++;
      $display("FAIL hold_last got v=%b bits=%h busy=%b cnt=%0d exp v=1 bits=c3 busy=0 cnt=%0d",
               valid, bits, busy, count, exp_count);
    end
    tick();
  endtask

  task automatic test_start_during_scan();
    cont  = 1'b0;
    ready = 1'b1;
    launch(8'h69);
    repeat (3) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (sel !== 3'd4 || busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_start got sel=%0d busy=%b exp sel=4 busy=1", sel, busy);
    end
    repeat (3) tick();
    checks++;
    if (sel !== 3'd7 || valid !== 1'b0) begin
      errors++;
      $display("FAIL busy_seq got sel=%0d v=%b exp sel=7 v=0", sel, valid);
    end
    tick();
    exp_count++;
    checks++;
    if (valid !== 1'b1 || bits !== 8'h69 || busy !== 1'b0 || count !== exp_count) begin
      errors++;
      $display("FAIL busy_word got v=%b bits=%h busy=%b cnt=%0d exp v=1 bits=69 busy=0 cnt=%0d",
               valid, bits, busy, count, exp_count);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    cont  = 1'b0;
    ready = 1'b1;
    launch(8'hFF);
    repeat (4) tick();
    checks++;
    if (sel !== 3'd4) begin
      errors++;
      $display("FAIL rstmid_pre got sel=%0d exp 4", sel);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_count = 8'd0;
    checks++;
    if ({sel, busy, valid, bits, count} !== 21'd0) begin
      errors++;
      $display("FAIL rstmid_state got sel=%0d busy=%b valid=%b bits=%h cnt=%0d exp all zero",
               sel, busy, valid, bits, count);
    end
    repeat (10) tick();
    checks++;
    if (valid !== 1'b0 || busy !== 1'b0 || count !== 8'd0) begin
      errors++;
      $display("FAIL rstmid_noword got v=%b busy=%b cnt=%0d exp v=0 busy=0 cnt=0",
               valid, busy, count);
    end
    launch(8'h96);
    repeat (8) tick();
    exp_count++;
    checks++;
    if (valid !== 1'b1 || bits !== 8'h96 || count !== exp_count) begin
      errors++;
      $display("FAIL rstmid_after got v=%b bits=%h cnt=%0d exp v=1 bits=96 cnt=%0d",
               valid, bits, count, exp_count);
    end
    tick();
  endtask

  task automatic test_wrap();
    int n;
    cont  = 1'b0;
    ready = 1'b1;
    n = 255 - int'(exp_count);
    for (int i = 0; i < n; i++) begin
      launch(8'(i));
      repeat (8) tick();
      exp_count++;
      tick();
    end
    checks++;
    if (count !== 8'd255) begin
      errors++;
      $display("FAIL wrap_255 got cnt=%0d exp 255", count);
    end
    launch(8'h81);
    repeat (8) tick();
    checks++;
    if (count !== 8'd0 || valid !== 1'b1 || bits !== 8'h81) begin
      errors++;
      $display("FAIL wrap_zero got cnt=%0d v=%b bits=%h exp cnt=0 v=1 bits=81",
               count, valid, bits);
    end
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    start  = 1'b0;
    cont   = 1'b0;
    ready  = 1'b1;
    pat    = 8'h00;
    test_reset();
    test_single();
    test_continuous();
    test_hold();
    test_start_during_scan();
    test_reset_mid();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
